rv32im_writeback: RTL
=====================

# rv32im_writeback

Writeback stage directly upstream of the register file: it collects results from the ALU, the multiply/divide unit and the load/store unit, grants one result per cycle and drives the register file write port. A per-register busy scoreboard holds back issue of instructions whose operands or destination are still in flight. Forwarding flags cover the one-cycle window in which the register file has been written but its read port does not yet return the new value.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_BITS, 5, register address width (2^REG_BITS registers, x0 hardwired zero)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- lsu_valid_i / lsu_ready_o  in/out  1  load result handshake
- lsu_rd_i  in  REG_BITS  load destination
- lsu_data_i  in  XLEN  load data
- mdu_valid_i / mdu_ready_o, mdu_rd_i, mdu_data_i  same widths as above  multiply/divide result
- alu_valid_i / alu_ready_o, alu_rd_i, alu_data_i  same widths as above  ALU result
- issue_valid_i  in  1  decode wants to issue an instruction this cycle
- issue_rd_i, issue_rs1_i, issue_rs2_i  in  REG_BITS  issuing instruction's registers
- issue_stall_o  out  1  issue blocked by hazard
- write_o  out  1  register file write strobe
- rd_addr_o  out  REG_BITS  register file write address
- data_o  out  XLEN  register file write data
- rs1_addr_i, rs2_addr_i  in  REG_BITS  addresses currently presented to the register file read ports
- rs1_fwd_o, rs2_fwd_o  out  1  use data_o instead of register file output

## Operation
- Arbitration: fixed priority lsu > mdu > alu. Only the highest-priority valid source gets ready_o = 1. The other readies are 0. Readies are combinational from the valids. A transfer happens when valid & ready.
- Readies are all 0 while reset_i = 1.
- Write port:
  - On a transfer, the next edge loads rd_addr_o and data_o.
  - write_o = 1 if the transferred rd != 0, otherwise write_o = 0.
  - With no transfer, write_o = 0 and rd_addr_o/data_o hold their previous values.
- Scoreboard: busy bits for registers 1..2^REG_BITS-1. Register 0 is never busy.
- Set: on an edge where issue_valid_i = 1, issue_stall_o = 0 and issue_rd_i != 0, busy[issue_rd_i] is set.
- Clear: on an edge where a transfer with rd != 0 occurs, busy[rd] is cleared.
- Set and clear of the same register on the same edge: set wins, so the register stays busy.
- Stall condition: issue_stall_o = issue_valid_i & (busy[issue_rs1_i] | busy[issue_rs2_i] | busy[issue_rd_i]). This is combinational and uses current busy state; a clear on the same edge does not release the stall early.
- Issue attempted while issue_stall_o = 1: ignored, scoreboard unchanged.
- Forwarding: rs1_fwd_o = write_o & (rs1_addr_i == rd_addr_o); rs2_fwd_o is the same with rs2_addr_i. rd_addr_o is never 0 when write_o = 1, so x0 never forwards.
- A result arriving for a non-busy register (for example x0, or a register with no issue outstanding) is still written. No error is flagged.

## Timing
- Reset values: write_o = 0, rd_addr_o = 0, data_o = 0, all busy bits 0, issue_stall_o = 0.
- Reset applied mid-operation drops any in-flight grant and clears the whole scoreboard on that edge.
- Latency: a transfer at edge N produces write_o = 1 during cycle N to N+1. The register file commits at edge N+1. The busy bit clears at edge N.
- Throughput: one writeback per cycle. A source held off by a higher-priority source keeps valid and its payload stable until its ready is asserted.
- Forward window: rs*_fwd_o is valid for exactly the cycle in which write_o = 1.

## Test plan
- Reset: hold reset_i for 2 cycles with all valids high -> all readies 0, write_o = 0, data_o = 0, issue_stall_o = 0.
- Single ALU result: alu_valid_i = 1, alu_rd_i = 5, alu_data_i = 0xDEADBEEF -> alu_ready_o = 1. Next cycle: write_o = 1, rd_addr_o = 5, data_o = 0xDEADBEEF. The cycle after: write_o = 0.
- Contention: lsu (rd 3, 0x11), mdu (rd 4, 0x22) and alu (rd 6, 0x33) all valid and held -> writes appear on three consecutive cycles in the order rd 3, 4, 6. Each ready pulses for exactly one cycle.
- Scoreboard:
  - Issue rd = 7, then issue with rs1 = 7 -> issue_stall_o = 1.
  - After mdu writes rd 7, the stall drops in the cycle following the transfer.
  - Issue with rd = 0 never sets busy and never stalls.
- Simultaneous set/clear: in the same cycle, lsu transfers rd 9 and a new issue targets rd 9 -> busy[9] stays 1 and a later rs2 = 9 issue stalls.
- Forwarding and x0:
  - rs1_addr_i = 12 while write_o = 1 for rd_addr_o = 12 -> rs1_fwd_o = 1 for that cycle only.
  - ALU transfer with rd 0 -> write_o stays 0, rs1_fwd_o = 0 with rs1_addr_i = 0.

Source files
------------

// File: rtl/rv32im_writeback.sv
// rv32im_writeback: collects ALU, multiply/divide and load results, grants one
// per cycle with fixed priority lsu > mdu > alu, drives the register file write
// port, tracks in-flight destinations in a busy scoreboard, and raises
// forwarding flags for the cycle in which the register file is being written.
module rv32im_writeback #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,

    // load/store unit result
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [REG_BITS-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]     lsu_data_i,

    // multiply/divide unit result
    input  logic                mdu_valid_i,
    output logic                mdu_ready_o,
    input  logic [REG_BITS-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]     mdu_data_i,

    // ALU result
    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [REG_BITS-1:0] alu_rd_i,
    input  logic [XLEN-1:0]     alu_data_i,

    // issue hazard check
    input  logic                issue_valid_i,
    input  logic [REG_BITS-1:0] issue_rd_i,
    input  logic [REG_BITS-1:0] issue_rs1_i,
    input  logic [REG_BITS-1:0] issue_rs2_i,
    output logic                issue_stall_o,

    // register file write port
    output logic                write_o,
    output logic [REG_BITS-1:0] rd_addr_o,
    output logic [XLEN-1:0]     data_o,

    // register file read-port forwarding
    input  logic [REG_BITS-1:0] rs1_addr_i,
    input  logic [REG_BITS-1:0] rs2_addr_i,
    output logic                rs1_fwd_o,
    output logic                rs2_fwd_o
);

    localparam int unsigned NREG = 1 << REG_BITS;

    // grant / transfer
    logic                lsu_ready_s;
    logic                mdu_ready_s;
    logic                alu_ready_s;
    logic                xfer_s;
    logic [REG_BITS-1:0] xfer_rd_s;
    logic [XLEN-1:0]     xfer_data_s;

    // write port registers
    logic                write_r;
    logic [REG_BITS-1:0] rd_addr_r;
    logic [XLEN-1:0]     data_r;

    // scoreboard
    logic [NREG-1:0]     busy_r;
    logic [NREG-1:0]     set_mask_s;
    logic [NREG-1:0]     clr_mask_s;
    logic [NREG-1:0]     busy_nxt_s;
    logic                stall_s;
    logic                issue_accept_s;

    // Fixed-priority grant: only the highest-priority valid source sees ready; nothing is granted in reset.
    always_comb begin
        lsu_ready_s = 1'b0;
        mdu_ready_s = 1'b0;
        alu_ready_s = 1'b0;
        if (reset_i) begin
            lsu_ready_s = 1'b0;
        end else if (lsu_valid_i) begin
            lsu_ready_s = 1'b1;
        end else if (mdu_valid_i) begin
            mdu_ready_s = 1'b1;
        end else if (alu_valid_i) begin
            alu_ready_s = 1'b1;
        end else begin
            alu_ready_s = 1'b0;
        end
    end

    // Select the payload of the granted source; a grant always implies a transfer.
    always_comb begin
        xfer_s      = 1'b0;
        xfer_rd_s   = {REG_BITS{1'b0}};
        xfer_data_s = {XLEN{1'b0}};
        if (lsu_ready_s) begin
            xfer_s      = 1'b1;
            xfer_rd_s   = lsu_rd_i;
            xfer_data_s = lsu_data_i;
        end else if (mdu_ready_s) begin
            xfer_s      = 1'b1;
            xfer_rd_s   = mdu_rd_i;
            xfer_data_s = mdu_data_i;
        end else if (alu_ready_s) begin
            xfer_s      = 1'b1;
            xfer_rd_s   = alu_rd_i;
            xfer_data_s = alu_data_i;
        end else begin
            xfer_s      = 1'b0;
        end
    end

    // Register file write port: load address/data on a transfer, strobe only for rd != x0, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_r   <= 1'b0;
            rd_addr_r <= {REG_BITS{1'b0}};
            data_r    <= {XLEN{1'b0}};
        end else if (xfer_s) begin
            write_r   <= (xfer_rd_s != {REG_BITS{1'b0}});
            rd_addr_r <= xfer_rd_s;
            data_r    <= xfer_data_s;
        end else begin
            write_r   <= 1'b0;
        end
    end

    // Hazard check against the current busy state; a same-edge clear does not release the stall early.
    always_comb begin
        stall_s = 1'b0;
        if (issue_valid_i) begin
            stall_s = busy_r[issue_rs1_i] | busy_r[issue_rs2_i] | busy_r[issue_rd_i];
        end else begin
            stall_s = 1'b0;
        end
        issue_accept_s = issue_valid_i & ~stall_s & (issue_rd_i != {REG_BITS{1'b0}});
    end

    // Next busy state: clears from writebacks, then sets from accepted issues so set wins; x0 is never busy.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (xfer_s) begin
            clr_mask_s[xfer_rd_s] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        if (issue_accept_s) begin
            set_mask_s[issue_rd_i] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy scoreboard register; reset wipes every in-flight destination.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign lsu_ready_o   = lsu_ready_s;
    assign mdu_ready_o   = mdu_ready_s;
    assign alu_ready_o   = alu_ready_s;
    assign issue_stall_o = stall_s;
    assign write_o       = write_r;
    assign rd_addr_o     = rd_addr_r;
    assign data_o        = data_r;

    // rd_addr_o is never x0 while write_o is high, so x0 cannot forward.
    assign rs1_fwd_o = write_r & (rs1_addr_i == rd_addr_r);
    assign rs2_fwd_o = write_r & (rs2_addr_i == rd_addr_r);

endmodule
